// File: rtl/axis_video_framer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_video_framer_pkg
// Description : Shared definitions for the AXI4-Stream Video framer, the
//               rectify core downstream of it, and their benches.
//               - USER_WIDTH / SOF_BIT : layout of the axis_video tuser field
//               - status_e             : encoding of the framer status pulses
// Revision    : 1.0 - initial release
// ============================================================================
package axis_video_framer_pkg;

    // axis_video tuser field: a single bit, bit 0 marks start of frame.
    localparam int USER_WIDTH = 1;
    localparam int SOF_BIT    = 0;

    // One status event per accepted beat at most; the two pulses are
    // mutually exclusive, so a 2-bit encoding carries both.
    typedef enum logic [1:0] {
        STATUS_NONE        = 2'b00,
        STATUS_FRAME_DONE  = 2'b01,
        STATUS_FRAME_ERROR = 2'b10
    } status_e;

endpackage : axis_video_framer_pkg
`default_nettype wire

// File: rtl/axis_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : axis_skid_reg
// Description : Two-entry AXI4-Stream register slice (main + skid register).
//               Full throughput with a registered upstream ready. Output
//               order is strict FIFO: the skid entry always drains into the
//               main register before any new beat is accepted.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_valid/o_ready - upstream handshake, i_data payload
//               o_valid/i_ready - downstream handshake, o_data payload
// Revision    : 1.0 - initial release
// ============================================================================
module axis_skid_reg #(
    parameter int WIDTH = 34
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    logic             r_main_valid;
    logic             r_skid_valid;
    logic             r_ready;
    logic [WIDTH-1:0] r_main_data;
    logic [WIDTH-1:0] r_skid_data;

    logic w_in_xfer;
    logic w_out_xfer;
    logic w_main_load;

    always_comb begin
        w_in_xfer   = i_valid && r_ready;
        w_out_xfer  = r_main_valid && i_ready;
        // Main register may take a new value when it is empty or being consumed.
        w_main_load = !r_main_valid || w_out_xfer;
    end

    // Control: reset drops both valids and holds ready low; ready rises on
    // the first clock after reset and afterwards mirrors !skid_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_ready      <= 1'b0;
        end else begin
            if (w_main_load) begin
                // Skid (if occupied) has priority; ready was low then, so
                // no input beat can compete with it.
                r_main_valid <= r_skid_valid || w_in_xfer;
                r_skid_valid <= 1'b0;
                r_ready      <= 1'b1;
            end else if (w_in_xfer) begin
                // Main is stalled: park the accepted beat in the skid.
                r_skid_valid <= 1'b1;
                r_ready      <= 1'b0;
            end
        end
    end

    // Payload registers are not reset; the valids qualify them.
    always_ff @(posedge clk) begin
        if (w_main_load) begin
            r_main_data <= r_skid_valid ? r_skid_data : i_data;
        end
        if (!w_main_load && w_in_xfer) begin
            r_skid_data <= i_data;
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_main_valid;
    assign o_data  = r_main_data;

endmodule : axis_skid_reg
`default_nettype wire

// File: rtl/axis_video_framer.sv
`default_nettype none
// ============================================================================
// Module      : axis_video_framer
// Description : Converts a frame-delimited pixel stream (tlast = end of
//               frame) into AXI4-Stream Video framing: tuser[SOF] on pixel
//               (0,0), tlast on the last pixel of every line. The incoming
//               tlast is checked against the x/y count; on disagreement an
//               error pulse is raised and counting restarts at a new frame.
// Ports       : clk, rst                  - clock, sync active-high reset
//               s_axis_*                  - input stream (tdata/tvalid/tready/tlast)
//               m_axis_*                  - video stream (tdata/tvalid/tready/tlast/tuser)
//               status_frame_done/error   - 1-cycle status pulses
//               status_x / status_y       - input-side pixel position
// Revision    : 1.0 - initial release
// ============================================================================
module axis_video_framer
    import axis_video_framer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int X_WIDTH    = $clog2(IMG_WIDTH),
    parameter int Y_WIDTH    = $clog2(IMG_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  status_frame_done,
    output logic                  status_frame_error,
    output logic [X_WIDTH-1:0]    status_x,
    output logic [Y_WIDTH-1:0]    status_y
);

    // Payload layout through the slice: {tuser, tlast, tdata}.
    localparam int                 c_PAYLOAD_W = DATA_WIDTH + USER_WIDTH + 1;
    localparam logic [X_WIDTH-1:0] c_X_LAST    = X_WIDTH'(IMG_WIDTH - 1);
    localparam logic [Y_WIDTH-1:0] c_Y_LAST    = Y_WIDTH'(IMG_HEIGHT - 1);

    logic [X_WIDTH-1:0] r_x;
    logic [Y_WIDTH-1:0] r_y;
    status_e            r_status;

    logic                   w_s_ready;
    logic                   w_accept;
    logic                   w_sof;
    logic                   w_eol;
    logic                   w_eof;
    logic [USER_WIDTH-1:0]  w_in_user;
    logic [USER_WIDTH-1:0]  w_out_user;
    logic [c_PAYLOAD_W-1:0] w_in_payload;
    logic [c_PAYLOAD_W-1:0] w_out_payload;

    always_comb begin
        w_accept          = s_axis_tvalid && w_s_ready;
        w_sof             = (r_x == '0) && (r_y == '0);
        w_eol             = (r_x == c_X_LAST);
        w_eof             = w_eol && (r_y == c_Y_LAST);
        w_in_user         = '0;
        w_in_user[SOF_BIT] = w_sof;
        w_in_payload      = {w_in_user, w_eol, s_axis_tdata};
    end

    // Position counters and frame check. Every accepted beat is forwarded
    // with its counted framing; a tlast mismatch only affects what the
    // *next* beat is counted as (forced back to (0,0)).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x      <= '0;
            r_y      <= '0;
            r_status <= STATUS_NONE;
        end else begin
            r_status <= STATUS_NONE;
            if (w_accept) begin
                if (s_axis_tlast != w_eof) begin
                    r_status <= STATUS_FRAME_ERROR;
                    r_x      <= '0;
                    r_y      <= '0;
                end else begin
                    if (w_eof) begin
                        r_status <= STATUS_FRAME_DONE;
                    end
                    if (w_eol) begin
                        r_x <= '0;
                        r_y <= (r_y == c_Y_LAST) ? '0 : r_y + Y_WIDTH'(1);
                    end else begin
                        r_x <= r_x + X_WIDTH'(1);
                    end
                end
            end
        end
    end

    axis_skid_reg #(
        .WIDTH (c_PAYLOAD_W)
    ) u_slice (
        .clk     (clk),
        .rst     (rst),
        .i_valid (s_axis_tvalid),
        .o_ready (w_s_ready),
        .i_data  (w_in_payload),
        .o_valid (m_axis_tvalid),
        .i_ready (m_axis_tready),
        .o_data  (w_out_payload)
    );

    assign w_out_user         = w_out_payload[c_PAYLOAD_W-1 -: USER_WIDTH];
    assign s_axis_tready      = w_s_ready;
    assign m_axis_tdata       = w_out_payload[DATA_WIDTH-1:0];
    assign m_axis_tlast       = w_out_payload[DATA_WIDTH];
    assign m_axis_tuser       = w_out_user[SOF_BIT];
    assign status_frame_done  = (r_status == STATUS_FRAME_DONE);
    assign status_frame_error = (r_status == STATUS_FRAME_ERROR);
    assign status_x           = r_x;
    assign status_y           = r_y;

endmodule : axis_video_framer
`default_nettype wire

// File: tb/tb_axis_video_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_video_framer
// Description : Directed self-checking bench for axis_video_framer on a 4x3
//               image: clean frame, output backpressure, early / missing
//               end-of-frame, mid-frame reset and random backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_video_framer;

    localparam int DW = 32;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);

    typedef struct packed {
        logic          user;
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic          s_tlast;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic          m_tuser;
    logic          f_done;
    logic          f_error;
    logic [XW-1:0] st_x;
    logic [YW-1:0] st_y;

    axis_video_framer #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .s_axis_tdata       (s_tdata),
        .s_axis_tvalid      (s_tvalid),
        .s_axis_tready      (s_tready),
        .s_axis_tlast       (s_tlast),
        .m_axis_tdata       (m_tdata),
        .m_axis_tvalid      (m_tvalid),
        .m_axis_tready      (m_tready),
        .m_axis_tlast       (m_tlast),
        .m_axis_tuser       (m_tuser),
        .status_frame_done  (f_done),
        .status_frame_error (f_error),
        .status_x           (st_x),
        .status_y           (st_y)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc      = 0;
    int    mode     = 0;   // 0: tready=1, 1: toggle, 2: random 70%
    int    done_cnt = 0;
    int    err_cnt  = 0;
    beat_t exp_q[$];
    beat_t obs_q[$];
    int    obs_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output-ready driver, updated just after each rising edge.
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0:       m_tready = 1'b1;
                1:       m_tready = ~m_tready;
                default: m_tready = ($urandom_range(0, 9) < 7);
            endcase
        end
    end

    // Monitor: collects output transfers and status pulses; checks that a
    // stalled output keeps valid high and its payload unchanged.
    initial begin
        beat_t cur;
        beat_t prev;
        logic  prev_stall;
        prev_stall = 1'b0;
        prev       = '0;
        forever begin
            @(negedge clk);
            cur = '{user: m_tuser, last: m_tlast, data: m_tdata};
            if (prev_stall && !rst) begin
                check("stall_valid", 64'(m_tvalid), 64'd1);
                check("stall_payload", 64'(cur), 64'(prev));
            end
            prev_stall = m_tvalid && !m_tready;
            prev       = cur;
            if (f_done)  done_cnt++;
            if (f_error) err_cnt++;
            if (m_tvalid && m_tready) begin
                obs_q.push_back(cur);
                obs_cyc.push_back(cyc);
            end
        end
    end

    // Presents one input beat; returns once it has been accepted, with the
    // cycle number of acceptance. Valid is left high for back-to-back beats.
    task automatic send_beat(input logic [DW-1:0] d, input logic l, output int acc_cyc);
        int   n;
        logic acc;
        n        = 0;
        acc      = 1'b0;
        acc_cyc  = -1;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = s_tready;
            if (acc) acc_cyc = cyc;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check("send_timeout", 64'(acc), 64'd1);
    endtask

    // Queue the expected output of one clean 4x3 frame.
    task automatic expect_frame(input logic [DW-1:0] base);
        for (int k = 0; k < W * H; k++) begin
            exp_q.push_back('{user: (k == 0), last: ((k % W) == W - 1), data: base + DW'(k)});
        end
    endtask

    // Send one frame of count beats, tlast on beat index tl_idx (-1: none).
    task automatic send_frame(input logic [DW-1:0] base, input int count, input int tl_idx,
                              output int first_acc);
        int c;
        first_acc = -1;
        for (int k = 0; k < count; k++) begin
            send_beat(base + DW'(k), (k == tl_idx), c);
            if (k == 0) first_acc = c;
        end
    endtask

    // Wait (bounded) for all expected beats, then compare against the queue.
    task automatic drain_compare(input string tag);
        int n;
        n        = 0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        while (obs_q.size() < exp_q.size() && n < 300) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check($sformatf("%s_beat%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
        end
    endtask

    task automatic clear_queues();
        exp_q.delete();
        obs_q.delete();
        obs_cyc.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fa;
        int d0;
        int e0;
        int n_eol;
        int n_sof;

        rst      = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_s_tready", 64'(s_tready), 64'd0);
        check("rst_x", 64'(st_x), 64'd0);
        check("rst_y", 64'(st_y), 64'd0);
        check("rst_done", 64'(f_done), 64'd0);
        check("rst_error", 64'(f_error), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_rst", 64'(s_tready), 64'd1);

        // 1: clean frame, no backpressure, latency 1, no bubbles.
        clear_queues();
        d0 = done_cnt; e0 = err_cnt;
        expect_frame(32'h0100_0000);
        send_frame(32'h0100_0000, 12, 11, fa);
        drain_compare("t1");
        if (obs_cyc.size() == 12) begin
            check("t1_latency", 64'(obs_cyc[0]), 64'(fa + 1));
            check("t1_no_bubble", 64'(obs_cyc[11] - obs_cyc[0]), 64'd11);
        end else begin
            check("t1_cyc_count", 64'(obs_cyc.size()), 64'd12);
        end
        check("t1_done", 64'(done_cnt - d0), 64'd1);
        check("t1_error", 64'(err_cnt - e0), 64'd0);

        // 2: output ready toggling 1010...
        clear_queues();
        mode = 1;
        d0 = done_cnt; e0 = err_cnt;
        expect_frame(32'h0200_0000);
        send_frame(32'h0200_0000, 12, 11, fa);
        drain_compare("t2");
        check("t2_done", 64'(done_cnt - d0), 64'd1);
        check("t2_error", 64'(err_cnt - e0), 64'd0);
        mode = 0;
        repeat (2) @(posedge clk);
        #1;

        // 3: early tlast on beat 7 (x=2,y=1), then a clean frame.
        clear_queues();
        d0 = done_cnt; e0 = err_cnt;
        for (int k = 0; k < 7; k++) begin
            exp_q.push_back('{user: (k == 0), last: (k == 3), data: 32'h0300_0000 + DW'(k)});
        end
        send_frame(32'h0300_0000, 7, 6, fa);
        check("t3_err_pulse", 64'(f_error), 64'd1);
        check("t3_x_resync", 64'(st_x), 64'd0);
        check("t3_y_resync", 64'(st_y), 64'd0);
        expect_frame(32'h0310_0000);
        send_frame(32'h0310_0000, 12, 11, fa);
        drain_compare("t3");
        check("t3_done", 64'(done_cnt - d0), 64'd1);
        check("t3_error", 64'(err_cnt - e0), 64'd1);

        // 4: missing tlast on beat 12, then a clean frame.
        clear_queues();
        d0 = done_cnt; e0 = err_cnt;
        expect_frame(32'h0400_0000);
        send_frame(32'h0400_0000, 12, -1, fa);
        check("t4_err_pulse", 64'(f_error), 64'd1);
        check("t4_no_done_pulse", 64'(f_done), 64'd0);
        expect_frame(32'h0410_0000);
        send_frame(32'h0410_0000, 12, 11, fa);
        drain_compare("t4");
        check("t4_done", 64'(done_cnt - d0), 64'd1);
        check("t4_error", 64'(err_cnt - e0), 64'd1);

        // 5: reset for one cycle after beat 6; beat 6 is already leaving.
        clear_queues();
        d0 = done_cnt; e0 = err_cnt;
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back('{user: (k == 0), last: (k == 3), data: 32'h0500_0000 + DW'(k)});
        end
        send_frame(32'h0500_0000, 6, -1, fa);
        rst      = 1'b1;
        s_tvalid = 1'b0;
        @(posedge clk);
        #1;
        check("t5_m_tvalid", 64'(m_tvalid), 64'd0);
        check("t5_s_tready", 64'(s_tready), 64'd0);
        check("t5_x", 64'(st_x), 64'd0);
        check("t5_y", 64'(st_y), 64'd0);
        rst = 1'b0;
        expect_frame(32'h0510_0000);
        send_frame(32'h0510_0000, 12, 11, fa);
        drain_compare("t5");
        check("t5_done", 64'(done_cnt - d0), 64'd1);
        check("t5_error", 64'(err_cnt - e0), 64'd0);

        // 6: three back-to-back frames with random 70% output ready.
        clear_queues();
        mode = 2;
        d0 = done_cnt; e0 = err_cnt;
        for (int f = 0; f < 3; f++) begin
            expect_frame(32'h0600_0000 + DW'(f * 32'h100));
        end
        for (int f = 0; f < 3; f++) begin
            send_frame(32'h0600_0000 + DW'(f * 32'h100), 12, 11, fa);
        end
        drain_compare("t6");
        n_eol = 0;
        n_sof = 0;
        foreach (obs_q[i]) begin
            if (obs_q[i].last) n_eol++;
            if (obs_q[i].user) n_sof++;
        end
        check("t6_eol", 64'(n_eol), 64'd9);
        check("t6_sof", 64'(n_sof), 64'd3);
        check("t6_done", 64'(done_cnt - d0), 64'd3);
        check("t6_error", 64'(err_cnt - e0), 64'd0);
        mode = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_axis_video_framer
`default_nettype wire
